booth_radix4_mult: RTL and testbench
====================================

BOOTH_RADIX4_MULT -- requirements
Module: booth_radix4_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits (even, >=4).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port op_start  input  1  level request to begin a multiply.
REQ-005 SHALL have port op_clear  input  1  synchronous abort/clear, returns block to IDLE.
REQ-006 SHALL have port multiplier  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port multiplicand  input  WIDTH  unsigned operand B.
REQ-008 SHALL have port op_done  output  1  registered; high while a valid product is held.
REQ-009 SHALL have port result  output  2*WIDTH  registered unsigned product A*B.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE, held in a state register.
REQ-011 SHALL, in IDLE with op_start=1 and op_clear=0 at a rising edge, capture both operands internally, clear the partial product and iteration counter, and enter BUSY.
REQ-012 SHALL ignore operand changes after capture until the next IDLE->BUSY transition.
REQ-013 SHALL perform one radix-4 Booth step per BUSY cycle on the operand zero-extended to WIDTH+2 bits, for exactly WIDTH/2+1 steps (33 for WIDTH=64).
REQ-014 SHALL, per step, select a partial product from {0, +B, +2B, -B, -2B} by the current 3-bit Booth window, add it into a (2*WIDTH+4)-bit sign-extended accumulator, then arithmetic-shift the window by 2.
REQ-015 SHALL, after the final step, load result with the low 2*WIDTH bits of the accumulator, set op_done=1 and enter DONE on the same edge.
REQ-016 SHALL give fixed latency: op_start sampled at edge N -> op_done=1 and result valid immediately after edge N+WIDTH/2+1 (N+33 for WIDTH=64), independent of operand values.
REQ-017 SHALL hold result and op_done=1 in DONE indefinitely, with op_start ignored (no restart while op_start stays high).
REQ-018 SHALL ignore op_start while in BUSY.
REQ-019 SHALL, on op_clear=1 at a rising edge in any state, go to IDLE, set op_done=0, result=0, counter=0; op_clear has priority over op_start in the same cycle.
REQ-020 SHALL, if op_start is still high on the first edge after op_clear deasserts, start a new operation from IDLE on that edge with the operands present then.
REQ-021 SHALL keep result exact for all unsigned operand pairs including 0 and 2^WIDTH-1 (no overflow, no truncation).
REQ-022 SHALL keep result=0 while in IDLE or BUSY; result never shows a partial product.

Reset
REQ-023 SHALL, on reset=1, asynchronously force state=IDLE, op_done=0, result=0, counter=0, accumulator=0 and internal operand registers=0, regardless of clock.
REQ-024 SHALL, on reset asserted mid-BUSY, discard the operation; after release, no op_done until a new op_start is accepted.
REQ-025 SHALL accept op_start on the first rising edge after reset deasserts.

Verification
REQ-026 Bench SHALL cover: A=3, B=5, op_start held from edge N -> op_done=0 through edge N+32, op_done=1 and result=15 after edge N+33.
REQ-027 Bench SHALL cover: A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 after 33 cycles; A=0, B=0xDEAD -> result=0, still 33-cycle latency.
REQ-028 Bench SHALL cover: op_clear pulsed at BUSY step 10 with op_start held, A changed to 7, B to 6 -> op_done=0, result=0 during clear; restart on next edge; result=42 33 cycles later.
REQ-029 Bench SHALL cover: reset asserted between clock edges at step 20 -> outputs 0 immediately (before next edge); after release with op_start=0 -> op_done stays 0 for 50 cycles.
REQ-030 Bench SHALL cover: op_start held high 100 cycles after op_done -> result and op_done=1 unchanged; op_clear and op_start both 1 in same cycle -> IDLE, op_done=0.
REQ-031 Bench SHALL cover: 1000 random operand pairs with random op_clear gaps -> every result equals a 128-bit reference product.

Source files
------------

// File: rtl/booth_radix4_mult_if.sv
// Operand/result bundle for booth_radix4_mult.
// The master drives operands and commands; the slave returns the product.
interface booth_radix4_mult_if #(
  parameter int unsigned WIDTH = 64
);
  logic               op_start;
  logic               op_clear;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               op_done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output op_start, op_clear, multiplier, multiplicand,
    input  op_done, result
  );

  modport slave (
    input  op_start, op_clear, multiplier, multiplicand,
    output op_done, result
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential unsigned multiplier: one radix-4 Booth step per cycle.
// Fixed latency of WIDTH/2+1 cycles from operand capture to op_done.
module booth_radix4_mult #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  booth_radix4_mult_if.slave  bus
);

  localparam int unsigned AW    = 2*WIDTH + 4;
  localparam int unsigned QW    = WIDTH + 3;
  localparam int unsigned STEPS = WIDTH/2 + 1;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [1:0]         r_state;
  logic [QW-1:0]      r_q;
  logic [AW-1:0]      r_b;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;

  logic [AW-1:0]      w_b2;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_sum;

  // r_b tracks B << 2*step, so each digit adds at a fixed position instead of
  // shifting the accumulator; the final sum is identical.
  always_comb begin
    w_b2 = {r_b[AW-2:0], 1'b0};
    w_pp = '0;
    case (r_q[2:0])
      3'b001, 3'b010: w_pp = r_b;
      3'b011:         w_pp = w_b2;
      3'b100:         w_pp = -w_b2;
      3'b101, 3'b110: w_pp = -r_b;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum = r_acc + w_pp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.op_clear) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.op_start) begin
            // Two zero guard bits on top keep the recoding of an unsigned A positive.
            r_q     <= {2'b00, bus.multiplier, 1'b0};
            r_b     <= AW'(bus.multiplicand);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_acc <= w_sum;
          r_q   <= {r_q[QW-1], r_q[QW-1], r_q[QW-1:2]};
          r_b   <= {r_b[AW-3:0], 2'b00};
          if (r_cnt == LAST) begin
            r_result <= w_sum[2*WIDTH-1:0];
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.op_done = r_done;
  assign bus.result  = r_result;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed and randomized checks of booth_radix4_mult at WIDTH=64.
module tb_booth_radix4_mult;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  booth_radix4_mult_if #(.WIDTH(64)) bus ();

  booth_radix4_mult #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues a one-cycle op_start, scrambles the operands after capture and
  // checks the fixed 33-cycle latency and the product.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
    bus.multiplier   = a;
    bus.multiplicand = b;
    bus.op_start     = 1'b1;
    step();
    bus.op_start     = 1'b0;
    bus.multiplier   = {$urandom(), $urandom()};
    bus.multiplicand = {$urandom(), $urandom()};
    repeat (32) step();
    chk("op_done_early", 128'(bus.op_done), 128'd0);
    chk("result_partial", bus.result, 128'd0);
    step();
    chk("op_done", 128'(bus.op_done), 128'd1);
    chk("product", bus.result, exp);
  endtask

  task automatic clear_pulse();
    bus.op_clear = 1'b1;
    step();
    bus.op_clear = 1'b0;
    chk("clear_done", 128'(bus.op_done), 128'd0);
    chk("clear_result", bus.result, 128'd0);
  endtask

  initial begin
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] ref_p;

    n_cmp = 0;
    n_bad = 0;
    reset            = 1'b1;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplier   = '0;
    bus.multiplicand = '0;
    repeat (3) step();
    chk("reset_done", 128'(bus.op_done), 128'd0);
    chk("reset_result", bus.result, 128'd0);

    // 3*5 with op_start held, accepted on the first edge after reset release
    reset            = 1'b0;
    bus.multiplier   = 64'd3;
    bus.multiplicand = 64'd5;
    bus.op_start     = 1'b1;
    step();
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("busy_done_3x5", 128'(bus.op_done), 128'd0);
      chk("busy_result_3x5", bus.result, 128'd0);
    end
    step();
    chk("done_3x5", 128'(bus.op_done), 128'd1);
    chk("result_3x5", bus.result, 128'd15);

    // op_start held in DONE with changing operands: no restart
    for (int k = 0; k < 100; k++) begin
      bus.multiplier   = 64'(k + 100);
      bus.multiplicand = 64'(k * 3 + 1);
      step();
      chk("hold_done", 128'(bus.op_done), 128'd1);
      chk("hold_result", bus.result, 128'd15);
    end

    // clear wins over start in the same cycle
    bus.op_clear = 1'b1;
    step();
    chk("clr_vs_start_done", 128'(bus.op_done), 128'd0);
    chk("clr_vs_start_result", bus.result, 128'd0);
    bus.op_clear     = 1'b0;
    bus.multiplier   = 64'd2;
    bus.multiplicand = 64'd21;
    step();
    bus.op_start = 1'b0;
    repeat (32) step();
    chk("restart_early", 128'(bus.op_done), 128'd0);
    step();
    chk("restart_done", 128'(bus.op_done), 128'd1);
    chk("restart_result", bus.result, 128'd42);
    clear_pulse();

    // operand extremes
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    clear_pulse();
    run_op(64'd0, 64'hDEAD, 128'd0);
    clear_pulse();
    run_op(64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000);
    clear_pulse();

    // abort at BUSY step 10, restart with 7*6 on the edge after clear
    bus.multiplier   = 64'd11;
    bus.multiplicand = 64'd13;
    bus.op_start     = 1'b1;
    step();
    repeat (10) step();
    bus.op_clear     = 1'b1;
    bus.multiplier   = 64'd7;
    bus.multiplicand = 64'd6;
    step();
    chk("abort_done", 128'(bus.op_done), 128'd0);
    chk("abort_result", bus.result, 128'd0);
    bus.op_clear = 1'b0;
    step();
    bus.op_start = 1'b0;
    repeat (32) step();
    chk("abort_restart_early", 128'(bus.op_done), 128'd0);
    step();
    chk("abort_restart_done", 128'(bus.op_done), 128'd1);
    chk("abort_restart_result", bus.result, 128'd42);

    // asynchronous reset from DONE clears outputs before the next edge
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_done", 128'(bus.op_done), 128'd0);
    chk("async_rst_result", bus.result, 128'd0);
    step();
    reset = 1'b0;

    // reset mid-BUSY discards the operation
    bus.multiplier   = 64'd9;
    bus.multiplicand = 64'd9;
    bus.op_start     = 1'b1;
    step();
    bus.op_start = 1'b0;
    repeat (20) step();
    #2;
    reset = 1'b1;
    #1;
    chk("busy_rst_done", 128'(bus.op_done), 128'd0);
    chk("busy_rst_result", bus.result, 128'd0);
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      chk("post_rst_idle", 128'(bus.op_done), 128'd0);
    end

    run_op(64'd123456789, 64'd987654321, 128'd121932631112635269);
    clear_pulse();

    for (int i = 0; i < 1000; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (i % 50 == 0) a = '1;
      if (i % 70 == 0) b = '0;
      ref_p = {64'd0, a} * {64'd0, b};
      run_op(a, b, ref_p);
      clear_pulse();
      repeat ($urandom_range(0, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
